// File: rtl/alu4_seq_ctrl.sv
// Sequencing stage in front of the 4-bit ALU: valid/ready command intake, registered
// ALU drive, one settle cycle, then result capture into the accumulator and a held result port.
module alu4_seq_ctrl #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_cmd,
   input  logic [3:0]       in_data,
   input  logic [3:0]       in_i3,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [3:0]       alu_i3,
   output logic [1:0]       alu_op,
   output logic             alu_add_sub,
   input  logic [3:0]       alu_f,
   input  logic             alu_zero,
   input  logic             alu_overflow,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_f,
   output logic             out_zero,
   output logic             out_ovf,
   output logic [3:0]       acc,
   output logic             sticky_ovf,
   output logic [CNT_W-1:0] op_count
);

   localparam int unsigned DW = 4;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [DW-1:0]    alu_a_q, alu_b_q, alu_i3_q;
   logic [1:0]       alu_op_q;
   logic             alu_add_sub_q;
   logic [DW-1:0]    out_f_q;
   logic             out_zero_q, out_ovf_q;
   logic [DW-1:0]    acc_q;
   logic             sticky_ovf_q;
   logic [CNT_W-1:0] op_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_i3_q      <= '0;
         alu_op_q      <= '0;
         alu_add_sub_q <= 1'b0;
         out_f_q       <= '0;
         out_zero_q    <= 1'b0;
         out_ovf_q     <= 1'b0;
         acc_q         <= '0;
         sticky_ovf_q  <= 1'b0;
         op_count_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  in_ready_q <= 1'b0;
                  if (in_cmd[3]) begin
                     // LOAD and CLR answer directly without touching the ALU drive
                     out_valid_q <= 1'b1;
                     out_ovf_q   <= 1'b0;
                     state_q     <= RESP;
                     if (in_cmd[0]) begin
                        acc_q        <= '0;
                        sticky_ovf_q <= 1'b0;
                        out_f_q      <= '0;
                        out_zero_q   <= 1'b1;
                     end else begin
                        acc_q      <= in_data;
                        out_f_q    <= in_data;
                        out_zero_q <= (in_data == '0);
                     end
                  end else begin
                     alu_a_q       <= acc_q;
                     alu_b_q       <= in_data;
                     alu_i3_q      <= in_i3;
                     alu_op_q      <= in_cmd[1:0];
                     alu_add_sub_q <= in_cmd[2];
                     state_q       <= EXEC;
                  end
               end
            end
            EXEC: begin
               acc_q        <= alu_f;
               out_f_q      <= alu_f;
               out_zero_q   <= alu_zero;
               out_ovf_q    <= alu_overflow;
               sticky_ovf_q <= sticky_ovf_q | alu_overflow;
               if (op_count_q != '1) begin
                  op_count_q <= op_count_q + CNT_W'(1);
               end
               out_valid_q  <= 1'b1;
               state_q      <= RESP;
            end
            RESP: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_i3      = alu_i3_q;
   assign alu_op      = alu_op_q;
   assign alu_add_sub = alu_add_sub_q;
   assign out_f       = out_f_q;
   assign out_zero    = out_zero_q;
   assign out_ovf     = out_ovf_q;
   assign acc         = acc_q;
   assign sticky_ovf  = sticky_ovf_q;
   assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu4_seq_ctrl.sv
// Directed bench for alu4_seq_ctrl with a behavioural 4-bit add/sub ALU closing the loop.
module tb_alu4_seq_ctrl;

   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_cmd;
   logic [3:0]       in_data;
   logic [3:0]       in_i3;
   logic [3:0]       alu_a, alu_b, alu_i3;
   logic [1:0]       alu_op;
   logic             alu_add_sub;
   logic [3:0]       alu_f;
   logic             alu_zero, alu_overflow;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       out_f;
   logic             out_zero, out_ovf;
   logic [3:0]       acc;
   logic             sticky_ovf;
   logic [CNT_W-1:0] op_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu4_seq_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
      .in_data(in_data), .in_i3(in_i3),
      .alu_a(alu_a), .alu_b(alu_b), .alu_i3(alu_i3), .alu_op(alu_op),
      .alu_add_sub(alu_add_sub), .alu_f(alu_f), .alu_zero(alu_zero),
      .alu_overflow(alu_overflow),
      .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
      .out_zero(out_zero), .out_ovf(out_ovf), .acc(acc),
      .sticky_ovf(sticky_ovf), .op_count(op_count)
   );

   // Reference ALU: add/sub with signed overflow
   always_comb begin
      alu_f        = alu_add_sub ? (alu_a - alu_b) : (alu_a + alu_b);
      alu_zero     = (alu_f == 4'd0);
      alu_overflow = alu_add_sub ? ((alu_a[3] != alu_b[3]) && (alu_f[3] != alu_a[3]))
                                 : ((alu_a[3] == alu_b[3]) && (alu_f[3] != alu_a[3]));
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one command at a negedge, hold it across one rising edge, then drop it
   task automatic issue(input logic [3:0] cmd, input logic [3:0] d, input logic [3:0] i3);
      int w = 0;
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_cmd   = cmd;
      in_data  = d;
      in_i3    = i3;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int exp_cnt;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_cmd    = 4'd0;
      in_data   = 4'd0;
      in_i3     = 4'd0;
      out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;

      // Reset state
      chk("rst_in_ready",   32'(in_ready),    32'd1);
      chk("rst_out_valid",  32'(out_valid),   32'd0);
      chk("rst_acc",        32'(acc),         32'd0);
      chk("rst_alu_a",      32'(alu_a),       32'd0);
      chk("rst_alu_b",      32'(alu_b),       32'd0);
      chk("rst_alu_i3",     32'(alu_i3),      32'd0);
      chk("rst_alu_op",     32'(alu_op),      32'd0);
      chk("rst_alu_addsub", 32'(alu_add_sub), 32'd0);
      chk("rst_op_count",   32'(op_count),    32'd0);
      chk("rst_out_f",      32'(out_f),       32'd0);
      chk("rst_sticky",     32'(sticky_ovf),  32'd0);
      step();
      chk("idle_in_ready",  32'(in_ready),    32'd1);

      // LOAD 3 then ADD 4
      issue(4'b1000, 4'h3, 4'h0);
      chk("load3_valid",    32'(out_valid), 32'd1);
      chk("load3_out_f",    32'(out_f),     32'd3);
      chk("load3_zero",     32'(out_zero),  32'd0);
      chk("load3_acc",      32'(acc),       32'd3);
      chk("load3_in_ready", 32'(in_ready),  32'd0);
      chk("load3_alu_a",    32'(alu_a),     32'd0);
      step();
      chk("load3_done_rdy", 32'(in_ready),  32'd1);
      chk("load3_done_vld", 32'(out_valid), 32'd0);
      issue(4'b0000, 4'h4, 4'h5);
      chk("add_n1_alu_a",   32'(alu_a),       32'd3);
      chk("add_n1_alu_b",   32'(alu_b),       32'd4);
      chk("add_n1_alu_i3",  32'(alu_i3),      32'd5);
      chk("add_n1_alu_op",  32'(alu_op),      32'd0);
      chk("add_n1_addsub",  32'(alu_add_sub), 32'd0);
      chk("add_n1_valid",   32'(out_valid),   32'd0);
      step();
      chk("add_n2_valid",   32'(out_valid), 32'd1);
      chk("add_n2_out_f",   32'(out_f),     32'd7);
      chk("add_n2_zero",    32'(out_zero),  32'd0);
      chk("add_n2_ovf",     32'(out_ovf),   32'd0);
      chk("add_n2_acc",     32'(acc),       32'd7);
      chk("add_n2_count",   32'(op_count),  32'd1);
      step();

      // Overflow, zero via SUB, then CLR
      issue(4'b1000, 4'h7, 4'h0);
      step();
      issue(4'b0000, 4'h1, 4'h0);
      step();
      chk("ovf_out_f",   32'(out_f),      32'd8);
      chk("ovf_out_ovf", 32'(out_ovf),    32'd1);
      chk("ovf_sticky",  32'(sticky_ovf), 32'd1);
      chk("ovf_count",   32'(op_count),   32'd2);
      step();
      issue(4'b0100, 4'h8, 4'h0);
      chk("sub_addsub",  32'(alu_add_sub), 32'd1);
      chk("sub_alu_a",   32'(alu_a),       32'd8);
      step();
      chk("sub_out_f",   32'(out_f),      32'd0);
      chk("sub_zero",    32'(out_zero),   32'd1);
      chk("sub_ovf",     32'(out_ovf),    32'd0);
      chk("sub_sticky",  32'(sticky_ovf), 32'd1);
      chk("sub_count",   32'(op_count),   32'd3);
      step();
      issue(4'b1001, 4'h6, 4'h0);
      chk("clr_acc",     32'(acc),        32'd0);
      chk("clr_sticky",  32'(sticky_ovf), 32'd0);
      chk("clr_zero",    32'(out_zero),   32'd1);
      chk("clr_out_f",   32'(out_f),      32'd0);
      chk("clr_count",   32'(op_count),   32'd3);
      chk("clr_valid",   32'(out_valid),  32'd1);
      step();

      // Back-pressure: results held, commands ignored
      out_ready = 1'b0;
      issue(4'b1000, 4'h5, 4'h0);
      for (int k = 0; k < 5; k++) begin
         in_valid = ~in_valid;
         in_cmd   = 4'b1001;
         in_data  = 4'(k + 9);
         step();
         chk("hold_valid",    32'(out_valid), 32'd1);
         chk("hold_out_f",    32'(out_f),     32'd5);
         chk("hold_in_ready", 32'(in_ready),  32'd0);
         chk("hold_acc",      32'(acc),       32'd5);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("release_in_ready", 32'(in_ready),  32'd1);
      chk("release_valid",    32'(out_valid), 32'd0);
      chk("release_acc",      32'(acc),       32'd5);

      // Reset during EXEC discards the capture
      issue(4'b0000, 4'h2, 4'h0);
      chk("exec_alu_a", 32'(alu_a), 32'd5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstx_valid",    32'(out_valid),  32'd0);
      chk("rstx_acc",      32'(acc),        32'd0);
      chk("rstx_count",    32'(op_count),   32'd0);
      chk("rstx_in_ready", 32'(in_ready),   32'd1);
      chk("rstx_alu_a",    32'(alu_a),      32'd0);
      chk("rstx_sticky",   32'(sticky_ovf), 32'd0);

      // Counter saturation over 257 increments of the accumulator
      for (int i = 0; i < 257; i++) begin
         issue(4'b0000, 4'h1, 4'h0);
         step();
         exp_cnt = (i + 1 > 255) ? 255 : i + 1;
         chk("sat_count", 32'(op_count), 32'(exp_cnt));
         chk("sat_out_f", 32'(out_f),    32'((i + 1) % 16));
         step();
      end
      chk("sat_final", 32'(op_count), 32'hFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
